// File: rtl/adsr_pkg.sv
// adsr_pkg -- shared state encoding and constants for the ADSR envelope stage. Rev 1.0
`default_nettype none

package adsr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } adsr_state_t;

   localparam logic [15:0] LEVEL_MAX        = 16'hFFFF;
   localparam int          TICK_DIV_DEFAULT = 12288;

endpackage

`default_nettype wire

// File: rtl/adsr_envelope_rate_tick.sv
// rate_tick -- free-running prescaler, one-cycle tick every TICK_DIV clocks. Rev 1.0
`default_nettype none

module rate_tick
   import adsr_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int             CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= '0;
      end else if (count_r == LAST) begin
         count_r <= '0;
      end else begin
         count_r <= count_r + 1'b1;
      end
   end

   assign tick = (count_r == LAST);

endmodule

`default_nettype wire

// File: rtl/adsr_envelope.sv
// adsr_envelope -- gate-driven ADSR level generator and signed sample scaler. Rev 1.0
`default_nettype none

module adsr_envelope
   import adsr_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT,
   parameter int LEVEL_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               gate,
   input  logic [15:0]        sample_in,
   input  logic [LEVEL_W-1:0] attack_step,
   input  logic [LEVEL_W-1:0] decay_step,
   input  logic [LEVEL_W-1:0] sustain_level,
   input  logic [LEVEL_W-1:0] release_step,
   output logic [15:0]        sample_out,
   output logic [LEVEL_W-1:0] level,
   output logic [2:0]         state,
   output logic               active
);

   localparam logic [LEVEL_W-1:0] FULL = '1;
   localparam int                 PW   = 16 + LEVEL_W + 1;

   adsr_state_t        state_r, state_n;
   logic [LEVEL_W-1:0] level_r, level_n;
   logic               active_r;
   logic [15:0]        sample_r;
   logic               tick;

   logic [LEVEL_W:0]   atk_sum;
   logic [LEVEL_W:0]   dec_diff;
   logic [LEVEL_W:0]   rel_diff;
   logic signed [PW-1:0] product;
   logic               unused_product;

   rate_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // One extra bit catches overflow (add) and underflow (sub) for saturation.
   assign atk_sum  = {1'b0, level_r} + {1'b0, attack_step};
   assign dec_diff = {1'b0, level_r} - {1'b0, decay_step};
   assign rel_diff = {1'b0, level_r} - {1'b0, release_step};

   always_comb begin
      state_n = state_r;
      level_n = level_r;
      case (state_r)
         ST_IDLE: begin
            level_n = '0;
            if (gate) state_n = ST_ATTACK;
         end
         ST_ATTACK: begin
            if (!gate) begin
               state_n = ST_RELEASE;
            end else if (tick) begin
               if (attack_step == '0 || atk_sum[LEVEL_W]) level_n = FULL;
               else                                     level_n = atk_sum[LEVEL_W-1:0];
               if (level_n == FULL) state_n = ST_DECAY;
            end
         end
         ST_DECAY: begin
            if (!gate) begin
               state_n = ST_RELEASE;
            end else if (tick) begin
               if (decay_step == '0 || dec_diff[LEVEL_W] ||
                   dec_diff[LEVEL_W-1:0] <= sustain_level) begin
                  level_n = sustain_level;
                  state_n = ST_SUSTAIN;
               end else begin
                  level_n = dec_diff[LEVEL_W-1:0];
               end
            end
         end
         ST_SUSTAIN: begin
            if (!gate) state_n = ST_RELEASE;
            else       level_n = sustain_level;
         end
         ST_RELEASE: begin
            // Retrigger keeps the current level so the attack ramps from there.
            if (gate) begin
               state_n = ST_ATTACK;
            end else if (tick) begin
               if (release_step == '0 || rel_diff[LEVEL_W] ||
                   rel_diff[LEVEL_W-1:0] == '0) begin
                  level_n = '0;
                  state_n = ST_IDLE;
               end else begin
                  level_n = rel_diff[LEVEL_W-1:0];
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            level_n = '0;
         end
      endcase
   end

   // Level is zero-extended so full scale stays positive in the signed product.
   assign product        = $signed(sample_in) * $signed({1'b0, level_r});
   assign unused_product = ^{product[PW-1], product[LEVEL_W-1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         level_r  <= '0;
         active_r <= 1'b0;
         sample_r <= '0;
      end else begin
         state_r  <= state_n;
         level_r  <= level_n;
         active_r <= (state_n != ST_IDLE);
         sample_r <= product[LEVEL_W+15:LEVEL_W];
      end
   end

   assign sample_out = sample_r;
   assign level      = level_r;
   assign state      = state_r;
   assign active     = active_r;

endmodule

`default_nettype wire

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope -- directed, table-driven check of the ADSR envelope with TICK_DIV=4. Rev 1.0
`default_nettype none

module tb_adsr_envelope;
   import adsr_pkg::*;

   localparam int TD = 4;

   typedef struct {
      logic        gate;
      logic [15:0] atk;
      logic [15:0] dec;
      logic [15:0] sus;
      logic [15:0] rel;
      bit          to_tick;
      logic [2:0]  st;
      logic [15:0] lvl;
   } env_vec_t;

   typedef struct {
      logic [15:0] lvl;
      logic [15:0] smp;
      logic [15:0] out;
   } scale_vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        gate;
   logic [15:0] sample_in;
   logic [15:0] atk, dec, sus, rel;
   logic [15:0] sample_out;
   logic [15:0] level;
   logic [2:0]  state;
   logic        active;

   int total = 0;
   int bad   = 0;
   int mcnt  = 0;
   bit last_tick = 1'b0;

   env_vec_t   ev[$];
   scale_vec_t sv[$];

   adsr_envelope #(
      .TICK_DIV (TD),
      .LEVEL_W  (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .gate          (gate),
      .sample_in     (sample_in),
      .attack_step   (atk),
      .decay_step    (dec),
      .sustain_level (sus),
      .release_step  (rel),
      .sample_out    (sample_out),
      .level         (level),
      .state         (state),
      .active        (active)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Advance one clock, keeping a model of the prescaler phase.
   task automatic clk1();
      @(posedge clk);
      last_tick = (mcnt == TD - 1);
      if (reset || mcnt == TD - 1) mcnt = 0;
      else                         mcnt = mcnt + 1;
      #1;
   endtask

   task automatic to_tick();
      do clk1(); while (!last_tick);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      // gate, atk, dec, sus, rel, through-next-tick, expected state, expected level
      ev.push_back('{1'b1, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b0, 3'd1, 16'h0000});
      ev.push_back('{1'b1, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b1, 3'd1, 16'h4000});
      ev.push_back('{1'b1, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b1, 3'd1, 16'h8000});
      ev.push_back('{1'b1, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b1, 3'd1, 16'hC000});
      ev.push_back('{1'b1, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b1, 3'd2, 16'hFFFF});
      ev.push_back('{1'b1, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b1, 3'd2, 16'hEFFF});
      ev.push_back('{1'b1, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b1, 3'd2, 16'hDFFF});
      ev.push_back('{1'b1, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b1, 3'd2, 16'hCFFF});
      ev.push_back('{1'b1, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b1, 3'd3, 16'hC000});
      ev.push_back('{1'b1, 16'h4000, 16'h1000, 16'hA000, 16'h8000, 1'b0, 3'd3, 16'hA000});
      ev.push_back('{1'b1, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b0, 3'd3, 16'hC000});
      ev.push_back('{1'b0, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b0, 3'd4, 16'hC000});
      ev.push_back('{1'b0, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b1, 3'd4, 16'h4000});
      ev.push_back('{1'b0, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b1, 3'd0, 16'h0000});
      ev.push_back('{1'b1, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b0, 3'd1, 16'h0000});
      ev.push_back('{1'b1, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b1, 3'd1, 16'h4000});
      ev.push_back('{1'b0, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b0, 3'd4, 16'h4000});
      ev.push_back('{1'b1, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b0, 3'd1, 16'h4000});
      ev.push_back('{1'b1, 16'h4000, 16'h1000, 16'hC000, 16'h8000, 1'b1, 3'd1, 16'h8000});
      ev.push_back('{1'b1, 16'h0000, 16'h1000, 16'hC000, 16'h8000, 1'b1, 3'd2, 16'hFFFF});
      ev.push_back('{1'b1, 16'h0000, 16'h0000, 16'hC000, 16'h8000, 1'b1, 3'd3, 16'hC000});
      ev.push_back('{1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'h8000, 1'b0, 3'd3, 16'hFFFF});
      ev.push_back('{1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 3'd4, 16'hFFFF});
      ev.push_back('{1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 3'd0, 16'h0000});
      ev.push_back('{1'b1, 16'h0000, 16'h1000, 16'hFFFF, 16'h0000, 1'b0, 3'd1, 16'h0000});
      ev.push_back('{1'b1, 16'h0000, 16'h1000, 16'hFFFF, 16'h0000, 1'b1, 3'd2, 16'hFFFF});
      ev.push_back('{1'b1, 16'h0000, 16'h1000, 16'hFFFF, 16'h0000, 1'b1, 3'd3, 16'hFFFF});
      ev.push_back('{1'b0, 16'h0000, 16'h1000, 16'hFFFF, 16'h0000, 1'b0, 3'd4, 16'hFFFF});
      ev.push_back('{1'b0, 16'h0000, 16'h1000, 16'hFFFF, 16'h0000, 1'b1, 3'd0, 16'h0000});

      // level, sample_in, expected floor((sample * level) / 2^16)
      sv.push_back('{LEVEL_MAX, 16'h4000, 16'h3FFF});
      sv.push_back('{16'h8000,  16'h8000, 16'hC000});
      sv.push_back('{16'h0000,  16'h7FFF, 16'h0000});
      sv.push_back('{16'h0000,  16'h8000, 16'h0000});
      sv.push_back('{LEVEL_MAX, 16'h8000, 16'h8000});
      sv.push_back('{LEVEL_MAX, 16'hFFFF, 16'hFFFF});
      sv.push_back('{LEVEL_MAX, 16'h7FFF, 16'h7FFE});
      sv.push_back('{16'h8000,  16'h0001, 16'h0000});
      sv.push_back('{16'h8000,  16'hFFFF, 16'hFFFF});
      sv.push_back('{16'h0001,  16'h8000, 16'hFFFF});

      reset = 1'b1; gate = 1'b0; sample_in = 16'h1234;
      atk = 16'h4000; dec = 16'h1000; sus = 16'hC000; rel = 16'h8000;
      clk1(); clk1();
      check("reset_state",  32'(state),      32'd0);
      check("reset_level",  32'(level),      32'd0);
      check("reset_sample", 32'(sample_out), 32'd0);
      check("reset_active", 32'(active),     32'd0);
      reset = 1'b0; sample_in = 16'h0000;

      foreach (ev[i]) begin
         gate = ev[i].gate; atk = ev[i].atk; dec = ev[i].dec;
         sus  = ev[i].sus;  rel = ev[i].rel;
         if (ev[i].to_tick) to_tick();
         else               clk1();
         check($sformatf("vec%0d_state", i),  32'(state),  32'(ev[i].st));
         check($sformatf("vec%0d_level", i),  32'(level),  32'(ev[i].lvl));
         check($sformatf("vec%0d_active", i), 32'(active), 32'(ev[i].st != 3'd0));
      end

      // Gate falls on the exact tick edge during ATTACK: transition wins, no step.
      atk = 16'h4000; rel = 16'h8000; gate = 1'b1;
      clk1();
      check("gtick_attack", 32'(state), 32'd1);
      to_tick();
      check("gtick_lvl0", 32'(level), 32'h4000);
      while (mcnt != TD - 1) clk1();
      gate = 1'b0;
      clk1();
      check("gtick_state", 32'(state), 32'd4);
      check("gtick_level", 32'(level), 32'h4000);
      rel = 16'h0000;
      to_tick();
      check("gtick_idle", 32'(state), 32'd0);

      // Reset mid-ATTACK at 0x8000; the prescaler must restart from zero.
      rel = 16'h8000; gate = 1'b1; sample_in = 16'h4000;
      clk1();
      to_tick();
      to_tick();
      check("rst_pre_level", 32'(level), 32'h8000);
      clk1();
      check("rst_pre_sample", 32'(sample_out), 32'h2000);
      reset = 1'b1;
      clk1();
      reset = 1'b0;
      check("rst_state",  32'(state),      32'd0);
      check("rst_level",  32'(level),      32'd0);
      check("rst_sample", 32'(sample_out), 32'd0);
      check("rst_active", 32'(active),     32'd0);
      clk1();
      check("rst_attack", 32'(state), 32'd1);
      clk1(); clk1();
      check("rst_no_tick", 32'(level), 32'h0000);
      clk1();
      check("rst_first_tick", 32'(level), 32'h4000);

      // Park in SUSTAIN so the level follows sustain_level every clock.
      atk = 16'h0000; dec = 16'h0000; sus = LEVEL_MAX; sample_in = 16'h0000;
      to_tick();
      to_tick();
      check("scale_sustain", 32'(state), 32'd3);
      foreach (sv[i]) begin
         sus = sv[i].lvl;
         clk1();
         sample_in = sv[i].smp;
         clk1();
         check($sformatf("scale%0d_level", i),  32'(level),      32'(sv[i].lvl));
         check($sformatf("scale%0d_sample", i), 32'(sample_out), 32'(sv[i].out));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
ADSR amplitude envelope stage. It sits between the triangle/square wave generator and the I2S controller on the slow audio clock. It scales each 16-bit sample by an envelope level driven by a note gate, so tones attack, decay, sustain and release instead of switching hard on and off. It also exposes its state for the seven-segment/GPIO debug path.

Parameters:
TICK_DIV, 12288, clocks per envelope step (1 ms at 12.288 MHz); must be >= 2
LEVEL_W, 16, envelope level width (unsigned, full scale = 2^LEVEL_W-1)

Ports:
clk  in  1  slow audio clock
reset  in  1  synchronous, active-high
gate  in  1  note held (1) / released (0)
sample_in  in  16  signed two's-complement sample from wave generator
attack_step  in  16  level increment per tick in ATTACK; 0 = instant
decay_step  in  16  level decrement per tick in DECAY; 0 = instant
sustain_level  in  16  SUSTAIN level and DECAY floor
release_step  in  16  level decrement per tick in RELEASE; 0 = instant
sample_out  out  16  signed scaled sample to I2S controller
level  out  16  current envelope level
state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
active  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset. Reset takes priority over everything in every state, including mid-step.
- Reset values: state=IDLE, level=0, sample_out=0, active=0, tick counter=0.
- Tick generation:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick=1 for the single cycle where counter==TICK_DIV-1.
  - The counter free-runs and is not restarted by gate.
- Level updates: all updates are registered and occur only on tick cycles, except where noted. New values are visible the following cycle.
- IDLE: level held at 0. gate=1 -> ATTACK next cycle.
- ATTACK:
  - On tick: level = min(level + attack_step, 0xFFFF), computed 17-bit with saturation.
  - attack_step=0: level = 0xFFFF on the next tick.
  - When the updated level is 0xFFFF -> DECAY, in the same update.
  - gate=0 -> RELEASE.
- DECAY:
  - On tick: level = max(level - decay_step, sustain_level), computed 17-bit with floor.
  - decay_step=0: level = sustain_level on the next tick.
  - Updated level == sustain_level -> SUSTAIN.
  - gate=0 -> RELEASE.
  - If sustain_level=0xFFFF, go to SUSTAIN on the first DECAY tick.
- SUSTAIN:
  - level is loaded from sustain_level every clock, so live changes are tracked.
  - gate=0 -> RELEASE.
- RELEASE:
  - On tick: level = max(level - release_step, 0).
  - release_step=0: level = 0 on the next tick.
  - level reaching 0 -> IDLE.
  - gate=1 -> ATTACK, retriggering from the current level with no reset to 0.
- Simultaneous events: a gate-driven transition in the same cycle as tick wins. The state changes and no level step is applied that cycle.
- Scaling:
  - sample_out <= (signed sample_in × signed {1'b0, level}) >>> 16. This is a 33-bit product; take bits [31:16], i.e. arithmetic-shift floor.
  - Registered with 1-cycle latency from sample_in/level to sample_out.
  - Updated every clock, independent of tick.
- Outputs: state, level and active are registered directly from internal registers.

Decomposition:
- Package adsr_pkg holds:
  - the state enum (3-bit, encodings above);
  - LEVEL_MAX = 16'hFFFF;
  - the default TICK_DIV constant.
- One sub-module, rate_tick: parameterised TICK_DIV prescaler with inputs clk and reset and output tick.
- Saturating add/sub and the scaling multiply stay inline.

Test Plan:
- Reset mid-ATTACK (level=0x8000), pulse reset one cycle -> next cycle: state=0, level=0, sample_out=0, active=0. The tick counter restarts, so the first tick follows TICK_DIV clocks later.
- TICK_DIV=4, attack_step=0x4000, gate 0->1 -> state=1 next cycle; level on successive ticks = 0x4000, 0x8000, 0xC000, 0xFFFF. State=2 after the 0xFFFF update.
- In DECAY with decay_step=0x1000, sustain_level=0xC000 -> level = 0xEFFF, 0xDFFF, 0xCFFF, then 0xC000 with state=3. Changing sustain_level to 0xA000 -> level=0xA000 next cycle.
- From SUSTAIN at 0xC000, gate=0, release_step=0x8000 -> state=4 next cycle; level = 0x4000, then 0x0000 with state=0 and active=0. A repeat run with gate=1 at level 0x4000 -> state=1 and ATTACK continues from 0x4000.
- gate falls on the exact tick cycle during ATTACK at level 0x4000 -> state=4, level stays 0x4000 that update.
- Level forced 0xFFFF (constant gate, attack_step=0): sample_in=0x4000 -> sample_out=0x3FFF one cycle later. At level=0x8000: sample_in=0x8000 -> sample_out=0xC000. At level=0: any sample_in -> sample_out=0x0000.
